cache_request_initiator: RTL and testbench

// CPU-side initiator for the set-associative cache's valid/rw/addr/wdata -> ready/rdata/hit interface.

---
 rtl/cache_initiator_pkg.sv | 26 ++
 rtl/cache_cmd_fifo.sv | 62 ++++++
 rtl/cache_request_initiator.sv | 164 ++++++++++++++++
 tb/tb_cache_request_initiator.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_initiator_pkg.sv
// Shared types for the cache request initiator: FSM states plus the packed
// command and response records carried between the FIFO, FSM and ports.
package cache_initiator_pkg;

    localparam int CI_ADDR_W = 16;
    localparam int CI_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    typedef struct packed {
        logic                 rw;
        logic [CI_ADDR_W-1:0] addr;
        logic [CI_DATA_W-1:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic                 rw;
        logic                 hit;
        logic [CI_DATA_W-1:0] rdata;
    } rsp_t;

endpackage

// File: rtl/cache_cmd_fifo.sv
// Command FIFO for the cache request initiator: wrap-around pointers plus an
// occupancy count. A push into a full FIFO is refused even if a pop coincides.
module cache_cmd_fifo
    import cache_initiator_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  cmd_t din,
    output logic full,
    output logic empty,
    output cmd_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    cmd_t             mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents are only meaningful behind the pointers.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

endmodule

// File: rtl/cache_request_initiator.sv
// CPU-side initiator: queues load/store commands, issues each to the cache,
// returns in-order responses and keeps saturating first-attempt hit/miss counts.
module cache_request_initiator
    import cache_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH = CI_ADDR_W,
    parameter int DATA_WIDTH = CI_DATA_W,
    parameter int CMD_DEPTH  = 4,
    parameter int CNT_WIDTH  = 16,
    parameter int READ_RETRY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_rw,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
    output logic                  o_cache_valid,
    output logic                  o_cache_rw,
    output logic [ADDR_WIDTH-1:0] o_cache_addr,
    output logic [DATA_WIDTH-1:0] o_cache_wdata,
    input  logic                  i_cache_ready,
    input  logic [DATA_WIDTH-1:0] i_cache_rdata,
    input  logic                  i_cache_hit,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic                  o_rsp_rw,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_hit,
    input  logic                  i_clear_stats,
    output logic [CNT_WIDTH-1:0]  o_hit_count,
    output logic [CNT_WIDTH-1:0]  o_miss_count
);

    state_t               state_r;
    state_t               state_nxt_s;
    rsp_t                 rsp_r;
    rsp_t                 rsp_nxt_s;
    logic                 retry_r;
    logic                 retry_nxt_s;
    cmd_t                 cmd_in_s;
    cmd_t                 head_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 push_s;
    logic                 pop_s;
    logic                 issue_s;
    logic                 xfer_s;
    logic                 do_retry_s;
    logic [CNT_WIDTH-1:0] hit_cnt_r;
    logic [CNT_WIDTH-1:0] miss_cnt_r;

    assign o_cmd_ready = !rst && !fifo_full_s;
    assign push_s      = i_cmd_valid && o_cmd_ready;
    assign cmd_in_s    = {i_cmd_rw, i_cmd_addr, i_cmd_wdata};

    cache_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (cmd_in_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .head  (head_s)
    );

    assign issue_s    = (state_r == ISSUE);
    assign xfer_s     = issue_s && i_cache_ready;
    // Only the first attempt of a read miss is retried; the refill makes the second one hit.
    assign do_retry_s = (READ_RETRY != 0) && xfer_s && !head_s.rw && !i_cache_hit && !retry_r;

    assign o_cache_valid = issue_s;
    assign o_cache_rw    = issue_s ? head_s.rw    : 1'b0;
    assign o_cache_addr  = issue_s ? head_s.addr  : {ADDR_WIDTH{1'b0}};
    assign o_cache_wdata = issue_s ? head_s.wdata : {DATA_WIDTH{1'b0}};

    assign o_rsp_valid  = (state_r == RESP);
    assign o_rsp_rw     = rsp_r.rw;
    assign o_rsp_hit    = rsp_r.hit;
    assign o_rsp_rdata  = rsp_r.rdata;
    assign o_hit_count  = hit_cnt_r;
    assign o_miss_count = miss_cnt_r;

    // Next-state, FIFO pop and response capture.
    always_comb begin
        state_nxt_s = state_r;
        retry_nxt_s = retry_r;
        rsp_nxt_s   = rsp_r;
        pop_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (do_retry_s) begin
                    retry_nxt_s = 1'b1;
                end else if (xfer_s) begin
                    pop_s           = 1'b1;
                    rsp_nxt_s.rw    = head_s.rw;
                    rsp_nxt_s.hit   = i_cache_hit && !retry_r;
                    rsp_nxt_s.rdata = head_s.rw ? {DATA_WIDTH{1'b0}} : i_cache_rdata;
                    retry_nxt_s     = 1'b0;
                    state_nxt_s     = RESP;
                end else begin
                    state_nxt_s = ISSUE;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_nxt_s = fifo_empty_s ? IDLE : ISSUE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                retry_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM, retry flag and response register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            retry_r <= 1'b0;
            rsp_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            retry_r <= retry_nxt_s;
            rsp_r   <= rsp_nxt_s;
        end
    end

    // Saturating first-attempt statistics; clear has priority over an increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_r  <= {CNT_WIDTH{1'b0}};
            miss_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (i_clear_stats) begin
            hit_cnt_r  <= {CNT_WIDTH{1'b0}};
            miss_cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (xfer_s && !retry_r) begin
            if (i_cache_hit) begin
                if (hit_cnt_r != {CNT_WIDTH{1'b1}}) begin
                    hit_cnt_r <= hit_cnt_r + CNT_WIDTH'(1);
                end
            end else begin
                if (miss_cnt_r != {CNT_WIDTH{1'b1}}) begin
                    miss_cnt_r <= miss_cnt_r + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_request_initiator.sv
// Scoreboard bench: two initiators (read retry on with 4-bit counters, read retry
// off with 16-bit counters) each attached to a behavioural write-allocate cache.
module tb_cache_request_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid   [2];
    logic        cmd_ready   [2];
    logic        cmd_rw      [2];
    logic [15:0] cmd_addr    [2];
    logic [31:0] cmd_wdata   [2];
    logic        cache_valid [2];
    logic        cache_rw    [2];
    logic [15:0] cache_addr  [2];
    logic [31:0] cache_wdata [2];
    logic        cache_ready [2];
    logic [31:0] cache_rdata [2];
    logic        cache_hit   [2];
    logic        rsp_valid   [2];
    logic        rsp_ready   [2];
    logic        rsp_rw      [2];
    logic        rsp_hit     [2];
    logic [31:0] rsp_rdata   [2];
    logic        clear_stats [2];
    logic [3:0]  hit_cnt0, miss_cnt0;
    logic [15:0] hit_cnt1, miss_cnt1;

    bit          vld [2][65536];
    bit   [31:0] mem [2][65536];
    int          xfers [2];
    logic [33:0] q0[$];
    logic [33:0] q1[$];
    int          tests;
    int          fails;

    always #5 clk = ~clk;

    cache_request_initiator #(
        .CMD_DEPTH(4), .CNT_WIDTH(4), .READ_RETRY(1)
    ) u_dut0 (
        .clk(clk), .rst(rst),
        .i_cmd_valid(cmd_valid[0]), .o_cmd_ready(cmd_ready[0]), .i_cmd_rw(cmd_rw[0]),
        .i_cmd_addr(cmd_addr[0]), .i_cmd_wdata(cmd_wdata[0]),
        .o_cache_valid(cache_valid[0]), .o_cache_rw(cache_rw[0]), .o_cache_addr(cache_addr[0]),
        .o_cache_wdata(cache_wdata[0]), .i_cache_ready(cache_ready[0]),
        .i_cache_rdata(cache_rdata[0]), .i_cache_hit(cache_hit[0]),
        .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]), .o_rsp_rw(rsp_rw[0]),
        .o_rsp_rdata(rsp_rdata[0]), .o_rsp_hit(rsp_hit[0]),
        .i_clear_stats(clear_stats[0]), .o_hit_count(hit_cnt0), .o_miss_count(miss_cnt0)
    );

    cache_request_initiator #(
        .CMD_DEPTH(4), .CNT_WIDTH(16), .READ_RETRY(0)
    ) u_dut1 (
        .clk(clk), .rst(rst),
        .i_cmd_valid(cmd_valid[1]), .o_cmd_ready(cmd_ready[1]), .i_cmd_rw(cmd_rw[1]),
        .i_cmd_addr(cmd_addr[1]), .i_cmd_wdata(cmd_wdata[1]),
        .o_cache_valid(cache_valid[1]), .o_cache_rw(cache_rw[1]), .o_cache_addr(cache_addr[1]),
        .o_cache_wdata(cache_wdata[1]), .i_cache_ready(cache_ready[1]),
        .i_cache_rdata(cache_rdata[1]), .i_cache_hit(cache_hit[1]),
        .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]), .o_rsp_rw(rsp_rw[1]),
        .o_rsp_rdata(rsp_rdata[1]), .o_rsp_hit(rsp_hit[1]),
        .i_clear_stats(clear_stats[1]), .o_hit_count(hit_cnt1), .o_miss_count(miss_cnt1)
    );

    // Cache model: same-cycle lookup; a read miss answers hit=0 rdata=0.
    always_comb begin
        for (int d = 0; d < 2; d++) begin
            cache_hit[d]   = vld[d][cache_addr[d]];
            cache_rdata[d] = (vld[d][cache_addr[d]] && !cache_rw[d]) ? mem[d][cache_addr[d]] : 32'h0;
        end
    end

    // Cache model update: write-allocate, read miss fills with all-ones.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (cache_valid[d] && cache_ready[d]) begin
                if (cache_rw[d]) begin
                    mem[d][cache_addr[d]] <= cache_wdata[d];
                    vld[d][cache_addr[d]] <= 1'b1;
                end else if (!vld[d][cache_addr[d]]) begin
                    mem[d][cache_addr[d]] <= 32'hFFFF_FFFF;
                    vld[d][cache_addr[d]] <= 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic mon_rsp(input int d);
        logic [33:0] act;
        logic [33:0] exp;
        bit          have;
        act  = {rsp_rw[d], rsp_hit[d], rsp_rdata[d]};
        exp  = '0;
        have = 1'b0;
        if (d == 0) begin
            if (q0.size() > 0) begin exp = q0.pop_front(); have = 1'b1; end
        end else begin
            if (q1.size() > 0) begin exp = q1.pop_front(); have = 1'b1; end
        end
        if (have) begin
            check($sformatf("rsp%0d", d), act, exp);
        end else begin
            tests++;
            fails++;
            $display("FAIL unexpected_rsp%0d: got %0h, expected no response", d, act);
        end
    endtask

    // Monitor: counts cache transfers and scores responses away from the active edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (cache_valid[d] && cache_ready[d]) xfers[d]++;
            if (rsp_valid[d] && rsp_ready[d]) mon_rsp(d);
        end
    end

    task automatic push(input int d, input logic rw, input logic [15:0] addr, input logic [31:0] wd,
                        input logic ehit, input logic [31:0] erd, input bit exp_rsp,
                        input int budget, output bit acc);
        acc          = 1'b0;
        cmd_valid[d] = 1'b1;
        cmd_rw[d]    = rw;
        cmd_addr[d]  = addr;
        cmd_wdata[d] = wd;
        for (int c = 0; c < budget && !acc; c++) begin
            @(negedge clk);
            if (cmd_ready[d]) begin
                acc = 1'b1;
                if (exp_rsp) begin
                    if (d == 0) q0.push_back({rw, ehit, erd});
                    else        q1.push_back({rw, ehit, erd});
                end
            end
            @(posedge clk); #1;
        end
        cmd_valid[d] = 1'b0;
    endtask

    task automatic push_req(input int d, input logic rw, input logic [15:0] addr, input logic [31:0] wd,
                            input logic ehit, input logic [31:0] erd, input bit exp_rsp);
        bit acc;
        push(d, rw, addr, wd, ehit, erd, exp_rsp, 20, acc);
        check("cmd_accept", acc, 1'b1);
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (((d == 0) ? q0.size() : q1.size()) != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("drain_pending", (d == 0) ? q0.size() : q1.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int x;
        int n;
        bit acc;
        tests = 0;
        fails = 0;
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d]   = 1'b0;
            cmd_rw[d]      = 1'b0;
            cmd_addr[d]    = 16'h0;
            cmd_wdata[d]   = 32'h0;
            cache_ready[d] = 1'b1;
            rsp_ready[d]   = 1'b1;
            clear_stats[d] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // 1. reset state
        check("rst_outs0", {cmd_ready[0], cache_valid[0], cache_rw[0], cache_addr[0], cache_wdata[0],
                            rsp_valid[0], rsp_rw[0], rsp_hit[0], rsp_rdata[0], hit_cnt0, miss_cnt0}, 128'h0);
        check("rst_outs1", {cmd_ready[1], cache_valid[1], rsp_valid[1], rsp_rdata[1], hit_cnt1, miss_cnt1}, 128'h0);
        rst = 1'b0;
        #1;
        check("rel_ready", cmd_ready[0], 1'b1);
        check("rel_cvalid", cache_valid[0], 1'b0);
        @(posedge clk); #1;

        // 2. write miss then read hit
        x = xfers[0];
        push_req(0, 1'b1, 16'h0040, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
        drain(0);
        check("wr_xfers", xfers[0] - x, 1);
        check("wr_miss", miss_cnt0, 4'd1);
        push_req(0, 1'b0, 16'h0040, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        drain(0);
        check("rd_hit", hit_cnt0, 4'd1);

        // 3. cold read miss with and without retry
        x = xfers[0];
        push_req(0, 1'b0, 16'h0123, 32'h0, 1'b0, 32'hFFFF_FFFF, 1'b1);
        drain(0);
        check("retry_xfers", xfers[0] - x, 2);
        check("retry_miss", miss_cnt0, 4'd2);
        check("retry_hitcnt", hit_cnt0, 4'd1);
        x = xfers[1];
        push_req(1, 1'b0, 16'h0123, 32'h0, 1'b0, 32'h0, 1'b1);
        drain(1);
        check("noretry_xfers", xfers[1] - x, 1);
        check("noretry_miss", miss_cnt1, 16'd1);
        check("noretry_hitcnt", hit_cnt1, 16'd0);

        // 4. response stall: 1 in RESP plus 4 queued, sixth refused
        rsp_ready[0] = 1'b0;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            push(0, 1'b0, (i % 2 == 1) ? 16'h0123 : 16'h0040, 32'h0, 1'b1,
                 (i % 2 == 1) ? 32'hFFFF_FFFF : 32'hDEAD_BEEF, 1'b1, 6, acc);
            n += int'(acc);
        end
        check("stall_accepted", n, 5);
        check("stall_ready", cmd_ready[0], 1'b0);
        x = xfers[0];
        repeat (5) @(posedge clk);
        #1;
        check("stall_no_xfer", xfers[0] - x, 0);
        check("stall_rsp_valid", rsp_valid[0], 1'b1);
        rsp_ready[0] = 1'b1;
        drain(0);
        check("stall_xfers_after", xfers[0] - x, 4);
        check("stall_hits", hit_cnt0, 4'd6);

        // 5. saturation and clear-over-increment
        for (int i = 0; i < 17; i++) begin
            push_req(0, 1'b1, 16'h1000 + 16'(i), 32'(i), 1'b0, 32'h0, 1'b1);
        end
        drain(0);
        check("sat_miss", miss_cnt0, 4'd15);
        check("sat_hit", hit_cnt0, 4'd6);
        push_req(0, 1'b0, 16'h0040, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1);
        n = 0;
        @(negedge clk);
        while (!cache_valid[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("clr_issue_seen", cache_valid[0], 1'b1);
        clear_stats[0] = 1'b1;
        @(posedge clk); #1;
        clear_stats[0] = 1'b0;
        check("clr_counts", {hit_cnt0, miss_cnt0}, 8'h00);
        drain(0);
        check("clr_counts_later", {hit_cnt0, miss_cnt0}, 8'h00);

        // 6. reset during ISSUE with three commands held
        rsp_ready[0] = 1'b0;
        push_req(0, 1'b1, 16'h2000, 32'h1111_1111, 1'b0, 32'h0, 1'b1);
        push_req(0, 1'b1, 16'h2001, 32'h2222_2222, 1'b0, 32'h0, 1'b0);
        push_req(0, 1'b1, 16'h2002, 32'h3333_3333, 1'b0, 32'h0, 1'b0);
        push_req(0, 1'b1, 16'h2003, 32'h4444_4444, 1'b0, 32'h0, 1'b0);
        rsp_ready[0] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cache_valid[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("mid_issue_seen", cache_valid[0], 1'b1);
        check("mid_miss_before", miss_cnt0, 4'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_cvalid", cache_valid[0], 1'b0);
        check("mid_rst_rvalid", rsp_valid[0], 1'b0);
        check("mid_rst_ready", cmd_ready[0], 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        x = xfers[0];
        repeat (10) @(posedge clk);
        #1;
        check("post_no_xfer", xfers[0] - x, 0);
        check("post_no_rsp", rsp_valid[0], 1'b0);
        check("post_ready", cmd_ready[0], 1'b1);
        check("post_counts0", {hit_cnt0, miss_cnt0}, 8'h00);
        check("post_counts1", {hit_cnt1, miss_cnt1}, 32'h0);
        check("post_queue", q0.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
